vga_timing_pipeline: RTL

// Parametrised VGA timing generator with a pixel-fetch interface and multi-bit colour output.

---
 rtl/vga_timing_pipeline.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_pipeline.sv
// Parametrised VGA timing generator: issues pixel addresses ahead of time and delays sync and
// blanking through a PIXEL_LATENCY-deep pipeline so they line up with the returned pixel data.
module vga_timing_pipeline #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 29,
  parameter bit          H_SYNC_POL    = 1'b0,
  parameter bit          V_SYNC_POL    = 1'b0,
  parameter int unsigned COLOR_BITS    = 1,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned PIXEL_LATENCY = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  output logic [CNT_W-1:0]        oColumn,
  output logic [CNT_W-1:0]        oRow,
  output logic                    oPixelRequest,
  output logic                    oFrameStart,
  input  logic [3*COLOR_BITS-1:0] iPixel,
  output logic                    oHorizontalSync,
  output logic                    oVerticalSync,
  output logic [COLOR_BITS-1:0]   oRed,
  output logic [COLOR_BITS-1:0]   oGreen,
  output logic [COLOR_BITS-1:0]   oBlue
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (Enable) begin
      if (col_q == HLast) begin
        col_d = '0;
        row_d = (row_q == VLast) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign oColumn       = col_q;
  assign oRow          = row_q;
  assign oPixelRequest = (col_q < HActive) && (row_q < VActive);
  assign oFrameStart   = (col_q == '0) && (row_q == '0) && Enable && !Reset;

  // Pipeline entries are {hs active, vs active, display}; all-zero is "blank, sync inactive".
  logic [2:0] cur;
  logic [2:0] tail;

  assign cur = {(col_q >= HSyncStart) && (col_q < HSyncEnd),
                (row_q >= VSyncStart) && (row_q < VSyncEnd),
                oPixelRequest};

  if (PIXEL_LATENCY == 0) begin : g_no_delay
    assign tail = cur;
  end else begin : g_delay
    logic [2:0] sr_q [PIXEL_LATENCY];
    logic [2:0] sr_d [PIXEL_LATENCY];

    always_comb begin
      sr_d = sr_q;
      if (Enable) begin
        sr_d[0] = cur;
        for (int i = 1; i < int'(PIXEL_LATENCY); i++) sr_d[i] = sr_q[i-1];
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        for (int i = 0; i < int'(PIXEL_LATENCY); i++) sr_q[i] <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign tail = sr_q[PIXEL_LATENCY-1];
  end

  logic                    hs_q, hs_d, vs_q, vs_d;
  logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    rgb_d = rgb_q;
    if (Enable) begin
      hs_d  = tail[2] ? H_SYNC_POL : !H_SYNC_POL;
      vs_d  = tail[1] ? V_SYNC_POL : !V_SYNC_POL;
      rgb_d = tail[0] ? iPixel : '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hs_q  <= !H_SYNC_POL;
      vs_q  <= !V_SYNC_POL;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign oHorizontalSync = hs_q;
  assign oVerticalSync   = vs_q;
  assign oRed            = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign oGreen          = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign oBlue           = rgb_q[COLOR_BITS-1:0];

endmodule
